secret_driver: RTL
==================

# secret_driver

Upstream/downstream shell for the `verilated_secret` protected-library wrapper. It accepts operand pairs on a valid/ready stream and buffers them in a small FIFO. It drives each pair onto the secret block's `a`/`b` inputs, holds them, samples `x` after a fixed latency, and returns the result on a valid/ready stream. It gives the rest of the design a flow-controlled interface to a block that has none.

## Interface
Parameters:
- `DEPTH`, 4: operand FIFO entries; power of two, ≥ 2.
- `LATENCY`, 1: cycles between `sec_a`/`sec_b` update and `sec_x` sample; 0 means the secret block is combinational.
- `W`, 32: operand/result width; must match the secret block.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `in_valid`, in, 1: operand pair valid.
- `in_ready`, out, 1: FIFO not full.
- `in_a`, in, W: operand a.
- `in_b`, in, W: operand b.
- `sec_a`, out, W: drives secret `a`; registered.
- `sec_b`, out, W: drives secret `b`; registered.
- `sec_x`, in, W: secret `x`.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: result accepted.
- `out_x`, out, W: captured result; registered.
- `busy`, out, 1: FSM not IDLE or FIFO non-empty.

## Operation
- FIFO push when `in_valid && in_ready`; `in_ready = (count != DEPTH)`. Pointers wrap modulo DEPTH. Push and pop in the same cycle leave count unchanged.
- FSM states are IDLE, APPLY and HOLD.
- IDLE: if FIFO non-empty, pop head into `sec_a`/`sec_b`, set `cnt <= LATENCY`, go to APPLY.
- APPLY:
  - if `cnt == 0`: `out_x <= sec_x`, `out_valid <= 1`, go to HOLD;
  - else `cnt--`.
- HOLD: `out_valid` and `out_x` stay stable until `out_valid && out_ready`. On that handshake clear `out_valid`. If the FIFO is non-empty, pop into `sec_a`/`sec_b` and go to APPLY in the same cycle; otherwise go to IDLE.
- `sec_a`/`sec_b` keep their last values between transactions. They never return to 0 except on reset, so the secret block sees no spurious input changes.
- Results leave in operand order. Nothing is dropped and nothing is duplicated.
- `cnt` is `$clog2(LATENCY+1)` bits wide, minimum 1.

## Timing
- Reset values: `in_ready=1`, `sec_a=0`, `sec_b=0`, `out_valid=0`, `out_x=0`, `busy=0`, FSM in IDLE, FIFO empty, `cnt=0`.
- Pop at edge t makes `sec_a`/`sec_b` visible in cycle t+1. `sec_x` is sampled at edge t+1+LATENCY, and `out_valid` is high from cycle t+2+LATENCY.
- Push at edge t with the FIFO empty and FSM in IDLE pops at edge t+1, so `out_valid` rises at cycle t+3+LATENCY.
- Sustained throughput with `out_ready=1`: one result per LATENCY+2 cycles.
- A full FIFO deasserts `in_ready` in the cycle after the filling push. A pop while full reasserts `in_ready` the next cycle.
- An `out_ready` stall backs up into the FIFO. Once DEPTH entries are held, `in_ready` stays 0 until the handshake.
- Reset mid-operation discards all in-flight and buffered pairs. All outputs return to their reset values at the next edge.

## Configuration
- `SECRET_DRV_STATS_EN`, when defined, adds two ports:
  - `stat_done` (out, 32): count of completed output handshakes;
  - `stat_stall` (out, 32): count of cycles with `out_valid && !out_ready`.
- Both counters reset to 0 and saturate at 32'hFFFF_FFFF.
- Without the macro both ports and their counters are absent. Datapath behaviour is identical either way.

## Structure
- Package `secret_drv_pkg` holds:
  - the `state_t` enum (IDLE, APPLY, HOLD);
  - the width constant `SECRET_W = 32`;
  - the pair struct `op_pair_t` {a, b}.
- Sub-module `secret_drv_fifo` is parameterised by DEPTH with `op_pair_t` entries. It provides push/pop/full/empty and synchronous active-low reset.

## Test plan
- Reset, then idle: `in_ready=1`, `out_valid=0`, `sec_a=sec_b=0`, `busy=0`.
- LATENCY=1, single push (a=5, b=7) with a model `x=a+b`: `out_x=12`, `out_valid` rises 4 cycles after the push edge, and clears after the handshake.
- Back-to-back pushes of (1,1), (2,2), (3,3) with `out_ready=1`: results 2, 4, 6 in order, one every 3 cycles.
- Hold `out_ready=0` and push 6 pairs with DEPTH=4: `in_ready` drops after the 4th buffered entry, and `out_x` is stable while stalled. With `STATS_EN`, `stat_stall` increments every stalled cycle.
- LATENCY=0 with a combinational model: `out_x` matches `sec_x` of the current pair, and throughput is one result per 2 cycles.
- Assert `rst_n=0` for one cycle during APPLY with 3 pairs queued: all outputs at reset values, no further results emitted, `stat_done=0`.

Source files
------------

// File: rtl/secret_drv_pkg.sv
// Shared types and constants for secret_driver: FSM state, operand pair, widths.
package secret_drv_pkg;

  localparam int SECRET_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic [SECRET_W-1:0] a;
    logic [SECRET_W-1:0] b;
  } op_pair_t;

  // Latency counter width: $clog2(latency+1), never narrower than one bit.
  function automatic int cnt_width(input int latency);
    int w;
    w = $clog2(latency + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/secret_drv_fifo.sv
// Operand-pair FIFO for secret_driver: power-of-two DEPTH, occupancy counter,
// synchronous active-low reset.
module secret_drv_fifo
  import secret_drv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_i,
  input  op_pair_t push_data_i,
  input  logic     pop_i,
  output op_pair_t pop_data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  op_pair_t      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  // NOTE: every variable is defaulted first so no path through the block leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q gates every read, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/secret_driver.sv
// Flow-controlled shell around the protected secret block: buffers operand pairs,
// drives sec_a/sec_b, samples sec_x after LATENCY cycles. Optional SECRET_DRV_STATS_EN adds counters.
module secret_driver
  import secret_drv_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 1,
  parameter int W       = SECRET_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic [W-1:0] sec_a,
  output logic [W-1:0] sec_b,
  input  logic [W-1:0] sec_x,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_x,
  output logic         busy
`ifdef SECRET_DRV_STATS_EN
  ,
  output logic [31:0]  stat_done,
  output logic [31:0]  stat_stall
`endif
);

  localparam int            CW       = cnt_width(LATENCY);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  sec_a_q, sec_a_d, sec_b_q, sec_b_d;
  logic [W-1:0]  out_x_q, out_x_d;
  logic          out_valid_q, out_valid_d;
  logic          fifo_pop, fifo_full, fifo_empty;
  op_pair_t      push_pair, head_pair;

  assign push_pair.a = in_a;
  assign push_pair.b = in_b;

  secret_drv_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (in_valid),
    .push_data_i (push_pair),
    .pop_i       (fifo_pop),
    .pop_data_o  (head_pair),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sec_a_d     = sec_a_q;
    sec_b_d     = sec_b_q;
    out_x_d     = out_x_q;
    out_valid_d = out_valid_q;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sec_a_d  = head_pair.a;
          sec_b_d  = head_pair.b;
          cnt_d    = CNT_INIT;
          state_d  = APPLY;
        end
      end
      APPLY: begin
        if (cnt_q == '0) begin
          out_x_d     = sec_x;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        // Chain straight into the next pair on the handshake to keep LATENCY+2 throughput.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            sec_a_d  = head_pair.a;
            sec_b_d  = head_pair.b;
            cnt_d    = CNT_INIT;
            state_d  = APPLY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sec_a_q     <= '0;
      sec_b_q     <= '0;
      out_x_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sec_a_q     <= sec_a_d;
      sec_b_q     <= sec_b_d;
      out_x_q     <= out_x_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = !fifo_full;
  assign sec_a     = sec_a_q;
  assign sec_b     = sec_b_q;
  assign out_x     = out_x_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;

`ifdef SECRET_DRV_STATS_EN
  logic [31:0] stat_done_q, stat_stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_done_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      if (out_valid_q && out_ready && !(&stat_done_q))   stat_done_q  <= stat_done_q + 1'b1;
      if (out_valid_q && !out_ready && !(&stat_stall_q)) stat_stall_q <= stat_stall_q + 1'b1;
    end
  end

  assign stat_done  = stat_done_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule
